// File: rtl/stream_pkg.sv
// Shared types and constants for the byte-stream consumer.
// Holds the assembly FSM state encoding and the lane width.
package stream_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/stream_byte_consumer.sv
// Packs an 8-bit byte stream into WORD_BYTES-wide words with a keep mask; optional STREAM_CONSUMER_PARITY_EN adds in_par/par_err.
// Latency: 1 cycle from the completing byte to out_valid when the output register is free.
// Backpressure: a completed word parks in the assembly register (HOLD, in_ready=0) until the output register drains.
module stream_byte_consumer
  import stream_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BYTE_W-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] out_word,
  output logic [WORD_BYTES-1:0]        out_keep,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef STREAM_CONSUMER_PARITY_EN
  ,
  input  logic                         in_par,
  output logic                         par_err
`endif
);

  localparam int CW = $clog2(WORD_BYTES);
  localparam int WW = BYTE_W * WORD_BYTES;
  localparam logic [CW-1:0] LAST_LANE = CW'(WORD_BYTES - 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           byte_cnt;
  logic [WW-1:0]           asm_word, asm_word_nxt;
  logic [WORD_BYTES-1:0]   asm_keep, asm_keep_nxt;
  logic                    asm_last;
  logic                    byte_acc, word_done, out_free;
  logic                    load_from_byte, load_from_hold;

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign in_ready  = rst_n && (state == FILL);
  assign byte_acc  = in_valid && in_ready;
  assign word_done = byte_acc && ((byte_cnt == LAST_LANE) || in_last);
  assign out_free  = !out_valid || out_ready;

  always_comb begin
    int lane;
    lane         = int'(byte_cnt);
    asm_word_nxt = asm_word;
    asm_keep_nxt = asm_keep;
    asm_word_nxt[lane*BYTE_W +: BYTE_W] = in_data;
    asm_keep_nxt[lane]                  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_from_byte = 1'b0;
    load_from_hold = 1'b0;
    case (state)
      FILL: begin
        if (word_done) begin
          if (out_free) begin
            load_from_byte = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          load_from_hold = 1'b1;
          state_nxt      = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      asm_word  <= '0;
      asm_keep  <= '0;
      asm_last  <= 1'b0;
      out_word  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_from_byte) begin
      // Completing byte bypasses the assembly register for zero-bubble throughput.
      out_word  <= asm_word_nxt;
      out_keep  <= asm_keep_nxt;
      out_last  <= in_last;
      out_valid <= 1'b1;
      asm_word  <= '0;
      asm_keep  <= '0;
      asm_last  <= 1'b0;
      byte_cnt  <= '0;
    end else if (load_from_hold) begin
      out_word  <= asm_word;
      out_keep  <= asm_keep;
      out_last  <= asm_last;
      out_valid <= 1'b1;
      asm_word  <= '0;
      asm_keep  <= '0;
      asm_last  <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (byte_acc) begin
        asm_word <= asm_word_nxt;
        asm_keep <= asm_keep_nxt;
        if (word_done) begin
          asm_last <= in_last;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

`ifdef STREAM_CONSUMER_PARITY_EN
  // Sticky error; in_par is expected to equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (byte_acc && ((^in_data) != in_par)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_byte_consumer.sv
// Randomized and directed bench for stream_byte_consumer against a byte-list packing model.
// Parity checks are included when STREAM_CONSUMER_PARITY_EN is defined.
module tb_stream_byte_consumer;

  localparam int WB = 4;
  localparam int WW = 8 * WB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [WW-1:0] out_word;
  logic [WB-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef STREAM_CONSUMER_PARITY_EN
  logic          in_par = 1'b0;
  logic          par_err;
  logic          par_flip = 1'b0;
`endif

  stream_byte_consumer #(.WORD_BYTES(WB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STREAM_CONSUMER_PARITY_EN
    ,
    .in_par    (in_par),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: accepted bytes collect in a list; a word is emitted when
  // the list reaches WB bytes or a byte flagged last arrives.
  logic [7:0]    pend[$];
  logic [WW-1:0] exp_w[$];
  logic [WB-1:0] exp_k[$];
  logic          exp_l[$];
  int            words_out = 0;
  bit            acc_now = 1'b0;
  bit            hold_prev = 1'b0;
  logic [WW-1:0] prev_word;
  logic [WB-1:0] prev_keep;
  logic          prev_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    logic [WW-1:0] w;
    logic [WB-1:0] k;
    pend.push_back(d);
    if (l || pend.size() == WB) begin
      w = '0;
      k = '0;
      for (int i = 0; i < pend.size(); i++) begin
        w[8*i +: 8] = pend[i];
        k[i]        = 1'b1;
      end
      exp_w.push_back(w);
      exp_k.push_back(k);
      exp_l.push_back(l);
      pend.delete();
    end
  endtask

  task automatic model_flush();
    pend.delete();
    exp_w.delete();
    exp_k.delete();
    exp_l.delete();
    hold_prev = 1'b0;
  endtask

  // Called right after a negedge with inputs already driven; observes the
  // handshakes the next posedge will perform, then returns at the following negedge.
  task automatic tick();
    #4;
    acc_now = 1'b0;
    if (rst_n) begin
      if (hold_prev) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_word", out_word, prev_word);
        check_val("hold_keep", out_keep, prev_keep);
        check_val("hold_last", out_last, prev_last);
      end
      if (in_valid && in_ready) begin
        acc_now = 1'b1;
        model_accept(in_data, in_last);
      end
      if (out_valid && out_ready) begin
        if (exp_w.size() == 0) begin
          check_val("spurious_word", out_word, 0);
        end else begin
          check_val("out_word", out_word, exp_w.pop_front());
          check_val("out_keep", out_keep, exp_k.pop_front());
          check_val("out_last", out_last, exp_l.pop_front());
        end
        words_out++;
      end
      hold_prev = out_valid && !out_ready;
      prev_word = out_word;
      prev_keep = out_keep;
      prev_last = out_last;
    end else begin
      hold_prev = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
`ifdef STREAM_CONSUMER_PARITY_EN
    in_par   = (^d) ^ par_flip;
`endif
    for (int n = 0; n < 50; n++) begin
      tick();
      if (acc_now) break;
    end
    if (!acc_now) check_val("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (exp_w.size() == 0 && !out_valid) break;
      tick();
    end
    check_val("drain_done", (exp_w.size() == 0) && !out_valid, 1);
  endtask

  // Entered and left aligned to a negedge.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_word", out_word, 0);
    check_val("rst_out_keep", out_keep, 0);
    check_val("rst_out_last", out_last, 0);
`ifdef STREAM_CONSUMER_PARITY_EN
    check_val("rst_par_err", par_err, 0);
`endif
    model_flush();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int drops;
    @(negedge clk);
    do_reset();

    // Full word, back-to-back, output ready
    out_ready = 1'b1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    check_val("full_valid", out_valid, 1);
    check_val("full_word", out_word, 32'h44332211);
    check_val("full_keep", out_keep, 4'hF);
    check_val("full_last", out_last, 0);
    drain();

    // Short packet
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    check_val("short_valid", out_valid, 1);
    check_val("short_word", out_word, 32'h0000BBAA);
    check_val("short_keep", out_keep, 4'h3);
    check_val("short_last", out_last, 1);
    drain();

    // Single-byte packet
    send_byte(8'h5A, 1);
    check_val("one_keep", out_keep, 4'h1);
    check_val("one_last", out_last, 1);
    drain();

    // Backpressure: second word parks in HOLD
    base = words_out;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i), 0);
    check_val("hold_in_ready", in_ready, 0);
    check_val("hold_first_word", out_word, 32'h53525150);
    for (int i = 0; i < 3; i++) tick();
    check_val("hold_still_blocked", in_ready, 0);
    drain();
    check_val("hold_word_count", words_out - base, 2);

    // Continuous stream never drops ready
    base  = words_out;
    drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
`ifdef STREAM_CONSUMER_PARITY_EN
      in_par   = ^in_data;
`endif
      tick();
      if (!acc_now) drops++;
    end
    in_valid = 1'b0;
    drain();
    check_val("stream_drops", drops, 0);
    check_val("stream_words", words_out - base, 16);

    // Reset mid-packet discards the partial word
    send_byte(8'hE1, 0);
    send_byte(8'hE2, 0);
    do_reset();
    base = words_out;
    out_ready = 1'b1;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    check_val("post_rst_word", out_word, 32'h04030201);
    check_val("post_rst_keep", out_keep, 4'hF);
    drain();
    check_val("post_rst_count", words_out - base, 1);

    // Randomized traffic with invalid-cycle garbage on data/last
    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || acc_now) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_last  = ($urandom_range(0, 5) == 0);
`ifdef STREAM_CONSUMER_PARITY_EN
        in_par   = ^in_data;
`endif
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    send_byte(8'hC3, 1);
    drain();
    check_val("rand_pending_bytes", pend.size(), 0);

`ifdef STREAM_CONSUMER_PARITY_EN
    check_val("par_clean", par_err, 0);
    base = words_out;
    par_flip = 1'b1;
    send_byte(8'h03, 1);
    par_flip = 1'b0;
    check_val("par_set", par_err, 1);
    drain();
    check_val("par_word_emitted", words_out - base, 1);
    send_byte(8'h10, 1);
    for (int i = 0; i < 5; i++) tick();
    check_val("par_sticky", par_err, 1);
    drain();
    do_reset();
    check_val("par_cleared", par_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
